// File: rtl/qpmm_pkg.sv
// qpmm_pkg: shared widths, latencies and record types for the QPMM command sequencer
package qpmm_pkg;
    localparam int WORD_W  = 272;
    localparam int ADDR_W  = 8;
    localparam int RD_LAT  = 2;
    localparam int MUL_LAT = 34;
    localparam int LAT     = RD_LAT + 1 + MUL_LAT;
    localparam int CNT_W   = 16;
    typedef logic [WORD_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef struct packed {addr_t src_a, src_b, dst;} cmd_t;
    typedef struct packed {logic v; addr_t dst;} trk_t;
endpackage

// File: rtl/qpmm_seq_if.sv
// qpmm_seq_if: command handshake carrying one (src_a, src_b, dst) triple
interface qpmm_seq_if;
    import qpmm_pkg::*;
    logic  valid;
    logic  ready;
    addr_t src_a;
    addr_t src_b;
    addr_t dst;
    modport master(output valid, src_a, src_b, dst, input ready);
    modport slave(input valid, src_a, src_b, dst, output ready);
endinterface

// File: rtl/qpmm_track.sv
// qpmm_track: LAT-deep in-flight destination tracker with read-after-write hazard lookup
module qpmm_track
    import qpmm_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  push,
    input  addr_t push_dst,
    input  addr_t q_a,
    input  addr_t q_b,
    output logic  hazard,
    output trk_t  tail,
    output logic  busy
);
    trk_t trk [LAT];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) trk[i] <= '0;
        end else begin
            trk[0] <= '{v: push, dst: push_dst};
            for (int i = 1; i < LAT; i++) trk[i] <= trk[i-1];
        end
    end
    always_comb begin
        hazard = 1'b0;
        busy   = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            hazard = hazard | (trk[i].v && (trk[i].dst == q_a || trk[i].dst == q_b));
            busy   = busy | trk[i].v;
        end
    end
    assign tail = trk[LAT-1];
endmodule

// File: rtl/qpmm_seq.sv
// qpmm_seq: issues operand reads, feeds the Montgomery multiplier and retires results in order
module qpmm_seq
    import qpmm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    qpmm_seq_if.slave        cmd,
    output addr_t            rd_addr_a,
    output addr_t            rd_addr_b,
    input  word_t            rd_data_a,
    input  word_t            rd_data_b,
    output word_t            mul_a,
    output word_t            mul_b,
    input  word_t            mul_z,
    output logic             wr_en,
    output addr_t            wr_addr,
    output word_t            wr_data,
    output logic             busy,
    output logic [CNT_W-1:0] done_cnt
);
    logic  hazard;
    logic  trk_busy;
    logic  accept;
    trk_t  tail;
    assign cmd.ready = !rst && !hazard;
    assign accept    = cmd.valid && cmd.ready;
    qpmm_track u_track (
        .clk      (clk),
        .rst      (rst),
        .push     (accept),
        .push_dst (cmd.dst),
        .q_a      (cmd.src_a),
        .q_b      (cmd.src_b),
        .hazard   (hazard),
        .tail     (tail),
        .busy     (trk_busy)
    );
    // The tail leaves the tracker into the write stage, so the destination being written no longer stalls readers
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            done_cnt  <= '0;
        end else begin
            if (accept) begin
                rd_addr_a <= cmd.src_a;
                rd_addr_b <= cmd.src_b;
            end
            mul_a    <= rd_data_a;
            mul_b    <= rd_data_b;
            wr_en    <= tail.v;
            wr_addr  <= tail.dst;
            done_cnt <= wr_en ? done_cnt + 1'b1 : done_cnt;
        end
    end
    assign wr_data = mul_z;
    assign busy    = trk_busy || wr_en;
endmodule

// File: tb/tb_qpmm_seq.sv
// tb_qpmm_seq: directed scoreboard bench with RAM and pipelined multiplier models around qpmm_seq
module tb_qpmm_seq;
    import qpmm_pkg::*;
    typedef struct {addr_t dst; word_t z; int cyc;} exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    qpmm_seq_if cmd_if();
    addr_t rd_addr_a, rd_addr_b, wr_addr;
    word_t rd_data_a = '0, rd_data_b = '0, mul_a, mul_b, mul_z, wr_data;
    logic wr_en, busy;
    logic [CNT_W-1:0] done_cnt;
    qpmm_seq dut (
        .clk(clk), .rst(rst), .cmd(cmd_if),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_z(mul_z),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done_cnt(done_cnt)
    );
    word_t m0 [256], m1 [256], g0 [256], g1 [256];
    word_t r0 = '0, r1 = '0;
    word_t pipe [MUL_LAT];
    exp_t q [$];
    int cyc = 0;
    int checks = 0;
    int failures = 0;
    function automatic word_t f(word_t a, word_t b);
        f = a * b + word_t'(1);
    endfunction
    task automatic chk(input string n, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask
    // RAM pair with a two-stage read path and the multiplier as a MUL_LAT-deep pipe
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc == 0) begin
            for (int i = 0; i < 256; i++) begin
                m0[i] <= word_t'(i + 2);
                m1[i] <= word_t'(i + 3);
            end
        end else if (wr_en) begin
            m0[wr_addr] <= wr_data;
            m1[wr_addr] <= wr_data;
        end
        r0 <= m0[rd_addr_a];
        r1 <= m1[rd_addr_b];
        rd_data_a <= r0;
        rd_data_b <= r1;
        pipe[0] <= f(mul_a, mul_b);
        for (int i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mul_z = pipe[MUL_LAT-1];
    always @(negedge clk) begin
        exp_t e;
        if (!rst && wr_en) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: wr_addr=%0d at cycle %0d with no pending command", wr_addr, cyc);
            end else begin
                e = q.pop_front();
                chk("wr_addr", word_t'(wr_addr), word_t'(e.dst));
                chk("wr_data", wr_data, e.z);
                chk("wr_cycle", word_t'(cyc), word_t'(e.cyc));
            end
        end
    end
    task automatic issue(input addr_t a, input addr_t b, input addr_t d, input bit trk,
                         output int acc, output int waits);
        word_t z;
        cmd_if.valid = 1'b1;
        cmd_if.src_a = a;
        cmd_if.src_b = b;
        cmd_if.dst   = d;
        waits = 0;
        @(negedge clk);
        while (!cmd_if.ready) begin
            waits++;
            if (waits > 100) begin
                failures++;
                $display("FAIL issue_timeout: stalled %0d cycles, required at most 100", waits);
                $fatal(1);
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        acc = cyc;
        cmd_if.valid = 1'b0;
        if (trk) begin
            z = f(g0[a], g1[b]);
            g0[d] = z;
            g1[d] = z;
            q.push_back('{d, z, acc + LAT});
        end
    endtask
    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || busy) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_pending", word_t'(q.size()), '0);
        chk("drain_busy", word_t'(busy), '0);
        repeat (2) @(posedge clk);
        #1;
    endtask
    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    initial begin
        int acc0, acc1, w0, w1, tw;
        logic [CNT_W-1:0] wexp [3];
        wexp[0] = 16'hFFFF;
        wexp[1] = 16'h0000;
        wexp[2] = 16'h0001;
        for (int i = 0; i < 256; i++) begin
            g0[i] = word_t'(i + 2);
            g1[i] = word_t'(i + 3);
        end
        cmd_if.valid = 1'b0;
        cmd_if.src_a = '0;
        cmd_if.src_b = '0;
        cmd_if.dst   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", word_t'(cmd_if.ready), '0);
        chk("rst_rd_addr_a", word_t'(rd_addr_a), '0);
        chk("rst_mul_a", mul_a, '0);
        chk("rst_wr_en", word_t'(wr_en), '0);
        chk("rst_busy", word_t'(busy), '0);
        chk("rst_done_cnt", word_t'(done_cnt), '0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", word_t'(cmd_if.ready), word_t'(1));
        issue(8'd3, 8'd4, 8'd10, 1'b1, acc0, w0);
        chk("single_busy", word_t'(busy), word_t'(1));
        repeat (3) @(posedge clk);
        #1;
        chk("single_mul_a", mul_a, word_t'(5));
        chk("single_mul_b", mul_b, word_t'(7));
        drain();
        chk("single_done_cnt", word_t'(done_cnt), word_t'(1));
        chk("single_ram", m0[10], word_t'(36));
        tw = 0;
        for (int i = 0; i < 40; i++) begin
            issue(addr_t'(i), addr_t'(i + 64), addr_t'(i + 128), 1'b1, acc1, w1);
            if (i == 0) acc0 = acc1;
            tw += w1;
        end
        chk("b2b_stalls", word_t'(tw), '0);
        chk("b2b_span", word_t'(acc1 - acc0), word_t'(39));
        drain();
        chk("b2b_done_cnt", word_t'(done_cnt), word_t'(41));
        issue(8'd1, 8'd2, 8'd20, 1'b1, acc0, w0);
        issue(8'd20, 8'd2, 8'd21, 1'b1, acc1, w1);
        chk("raw_stall_cycles", word_t'(w1), word_t'(37));
        chk("raw_accept_edge", word_t'(acc1 - acc0), word_t'(LAT + 1));
        repeat (3) @(posedge clk);
        #1;
        chk("raw_mul_a", mul_a, word_t'(16));
        chk("raw_mul_b", mul_b, word_t'(5));
        drain();
        chk("raw_ram", m0[21], word_t'(81));
        issue(8'd5, 8'd5, 8'd5, 1'b1, acc0, w0);
        issue(8'd6, 8'd6, 8'd5, 1'b1, acc1, w1);
        chk("waw_stalls", word_t'(w0 + w1), '0);
        drain();
        chk("waw_ram0", m0[5], word_t'(73));
        chk("waw_ram1", m1[5], word_t'(73));
        for (int i = 0; i < 10; i++) begin
            issue(addr_t'(i), addr_t'(i + 1), addr_t'(200 + i), 1'b0, acc1, w1);
            if (i == 0) acc0 = acc1;
        end
        while (cyc < acc0 + 14) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        chk("midrst_ready", word_t'(cmd_if.ready), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_wr_en", word_t'(wr_en), '0);
        chk("midrst_busy", word_t'(busy), '0);
        chk("midrst_done_cnt", word_t'(done_cnt), '0);
        chk("midrst_rd_addr_b", word_t'(rd_addr_b), '0);
        chk("midrst_mul_b", mul_b, '0);
        repeat (45) @(posedge clk);
        #1;
        chk("midrst_idle_busy", word_t'(busy), '0);
        chk("midrst_idle_done_cnt", word_t'(done_cnt), '0);
        issue(8'd3, 8'd4, 8'd11, 1'b1, acc0, w0);
        drain();
        chk("postrst_done_cnt", word_t'(done_cnt), word_t'(1));
        chk("postrst_ram", m0[11], word_t'(36));
        for (int n = 0; n < 65533; n++) issue(8'd0, 8'd1, 8'd2, 1'b1, acc0, w0);
        drain();
        chk("wrap_preset", word_t'(done_cnt), word_t'(16'hFFFE));
        for (int k = 0; k < 3; k++) begin
            issue(8'd0, 8'd1, 8'd2, 1'b1, acc0, w0);
            drain();
            chk("wrap_seq", word_t'(done_cnt), word_t'(wexp[k]));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
